fetch_stage: RTL and testbench

- Producer side of the IF/ID pipeline register. Owns the PC and the instruction-memory read handshake.
- Drives instr, currPC, PC_2 and the load enable into the IF/ID register.
- Honors the decode stall, inserts NOP on control redirects, and stops fetching after HALT.

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/pc_reg.sv | 22 ++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encoding and instruction constants for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} state_t;

    localparam logic [15:0] P_NOP_INSTR = 16'h0800;
    localparam logic [4:0]  P_HALT_OPC  = 5'b00000;

    function automatic logic is_halt(input logic [15:0] ins, input logic [4:0] opc);
        return ins[15:11] == opc;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: W-bit register with load enable and asynchronous active-low reset
//   i_clk   clock, rising edge
//   i_rst_n asynchronous reset, active low, loads RST_VAL
//   i_en    load enable
//   i_d     next value
//   o_q     registered value
module pc_reg #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) o_q <= RST_VAL;
        else if (i_en) o_q <= i_d;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction-memory handshake feeding the IF/ID register
//   clk, rst             clock (rising) and asynchronous active-low reset
//   stall_in             IF/ID must hold this cycle
//   redirect/redirect_pc taken control transfer; flushes IF/ID with a NOP
//   imem_*               single-outstanding read handshake (done may be same-cycle)
//   instr/currPC/PC_2    IF/ID payload, loaded when id_en=1
//   halted               HALT delivered, fetch stopped until redirect or reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = P_NOP_INSTR,
    parameter logic [4:0]  HALT_OPC  = P_HALT_OPC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] currPC,
    output logic [15:0] PC_2,
    output logic        id_en,
    output logic        halted
);

    state_t      r_state;
    logic        r_squash;
    logic [15:0] r_addr;
    logic [15:0] w_pc, w_pc_2, w_pc_d, w_hold, w_src;
    logic        w_busy, w_take, w_deliver, w_hold_en, w_pc_en;

    assign w_busy    = r_state == S_FETCH || r_state == S_WAIT;
    // a squashed access still completes on the bus but is never delivered
    assign w_take    = w_busy && imem_done && !r_squash;
    assign w_deliver = !redirect && !stall_in && (w_take || r_state == S_HOLD);
    assign w_hold_en = !redirect && stall_in && w_take;
    assign w_pc_en   = redirect || w_deliver;
    assign w_pc_2    = w_pc + 16'd2;
    assign w_pc_d    = redirect ? (redirect_pc & 16'hFFFE) : w_pc_2;
    assign w_src     = r_state == S_HOLD ? w_hold : imem_rdata;

    pc_reg #(.W(16), .RST_VAL(RESET_PC)) u_pc (
        .i_clk(clk), .i_rst_n(rst), .i_en(w_pc_en), .i_d(w_pc_d), .o_q(w_pc)
    );

    pc_reg #(.W(16), .RST_VAL(NOP_INSTR)) u_hold (
        .i_clk(clk), .i_rst_n(rst), .i_en(w_hold_en), .i_d(imem_rdata), .o_q(w_hold)
    );

    // outputs are gated by rst so reset values appear without waiting for a clock
    assign imem_rd   = rst && w_busy;
    // r_addr keeps the outstanding address stable even after a redirect moves pc
    assign imem_addr = r_state == S_WAIT ? r_addr : w_pc;
    assign id_en     = rst && w_pc_en;
    assign instr     = (rst && w_deliver) ? w_src : NOP_INSTR;
    assign currPC    = w_pc;
    assign PC_2      = w_pc_2;
    assign halted    = r_state == S_HALTED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FETCH;
            r_squash <= 1'b0;
            r_addr   <= RESET_PC;
        end else begin
            if (r_state == S_FETCH) r_addr <= w_pc;
            if (redirect) begin
                r_state  <= (w_busy && !imem_done) ? S_WAIT : S_FETCH;
                r_squash <= w_busy && !imem_done;
            end else if (w_busy && imem_done) begin
                r_squash <= 1'b0;
                r_state  <= r_squash ? S_FETCH :
                            stall_in ? S_HOLD :
                            is_halt(imem_rdata, HALT_OPC) ? S_HALTED : S_FETCH;
            end else if (w_busy) begin
                r_state <= S_WAIT;
            end else if (r_state == S_HOLD && !stall_in) begin
                r_state <= is_halt(w_hold, HALT_OPC) ? S_HALTED : S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a transaction-level model
module tb_fetch_stage;

    logic        clk, rst, stall_in, redirect, imem_done;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_rd, id_en, halted;
    logic [15:0] imem_addr, instr, currPC, PC_2;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_done(imem_done), .instr(instr),
        .currPC(currPC), .PC_2(PC_2), .id_en(id_en), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // memory contents and latency model
    logic [15:0] mem [0:255];
    bit          mem_act;
    int          mem_lat;

    // reference model: pc, pending access, one parked instruction, halt flag
    logic [15:0] m_pc, m_addr, m_held;
    bit          m_busy, m_drop, m_held_v, m_halted;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_addr = 16'h0000; m_held = 16'h0000;
        m_busy = 0; m_drop = 0; m_held_v = 0; m_halted = 0;
        mem_act = 0; mem_lat = 0;
    endtask

    task automatic step(input bit st, input bit rdr, input logic [15:0] rpc, input int lat, input bit hlt);
        logic        e_rd, e_en, dn, got, dlv;
        logic [15:0] e_addr, e_instr, rdat;
        @(negedge clk);
        e_rd   = !m_halted && !m_held_v;
        e_addr = m_busy ? m_addr : m_pc;
        if (e_rd && !mem_act) begin
            mem_act = 1;
            mem_lat = lat < 0 ? int'($urandom_range(0, 3)) : lat;
        end
        dn   = e_rd && mem_lat == 0;
        rdat = dn ? (hlt ? 16'h0000 : mem[e_addr[8:1]]) : 16'($urandom);
        stall_in = st; redirect = rdr; redirect_pc = rpc;
        imem_done = dn; imem_rdata = rdat;
        #1;
        got     = dn && !m_drop;
        dlv     = !rdr && !st && (got || m_held_v);
        e_en    = rdr || dlv;
        e_instr = rdr ? 16'h0800 : (m_held_v ? m_held : rdat);
        chk("imem_rd", 16'(imem_rd), 16'(e_rd));
        chk("imem_addr", imem_addr, e_addr);
        chk("id_en", 16'(id_en), 16'(e_en));
        chk("currPC", currPC, m_pc);
        chk("PC_2", PC_2, m_pc + 16'd2);
        chk("halted", 16'(halted), 16'(m_halted));
        if (e_en) chk("instr", instr, e_instr);
        if (e_rd) begin
            if (dn) mem_act = 0;
            else mem_lat--;
        end
        if (rdr) begin
            m_drop = e_rd && !dn;
            m_busy = m_drop;
            m_addr = e_addr;
            m_held_v = 0;
            m_halted = 0;
            m_pc = rpc & 16'hFFFE;
        end else if (e_rd) begin
            if (!dn) begin
                m_busy = 1;
                m_addr = e_addr;
            end else begin
                m_busy = 0;
                if (m_drop) m_drop = 0;
                else if (st) begin
                    m_held_v = 1;
                    m_held = rdat;
                end else begin
                    m_pc += 16'd2;
                    m_halted = rdat[15:11] == 5'b00000;
                end
            end
        end else if (m_held_v && !st) begin
            m_pc += 16'd2;
            m_halted = m_held[15:11] == 5'b00000;
            m_held_v = 0;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst imem_rd", 16'(imem_rd), 16'h0);
        chk("rst id_en", 16'(id_en), 16'h0);
        chk("rst instr", instr, 16'h0800);
        chk("rst currPC", currPC, 16'h0000);
        chk("rst PC_2", PC_2, 16'h0002);
        chk("rst halted", 16'(halted), 16'h0);
    endtask

    initial begin
        rst = 1'b0; stall_in = 0; redirect = 0; redirect_pc = 0;
        imem_done = 0; imem_rdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) | 16'h0800;
        model_reset();
        #2;
        chk_reset_vals();
        @(posedge clk); #1 rst = 1'b1;

        // zero-wait fetch from 0x0000
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("zw currPC", currPC, 16'h0006);

        // three-cycle latency at 0x0010
        step(0, 1, 16'h0010, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 3, 0);
        chk("lat currPC", currPC, 16'h0010);
        chk("lat id_en", 16'(id_en), 16'h1);

        // stall while 0x1234 returns at 0x0012
        mem[9] = 16'h1234;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("stall id_en", 16'(id_en), 16'h0);
        step(0, 0, 0, 0, 0);
        chk("stall instr", instr, 16'h1234);

        // redirect to 0x0101 in WAIT with stall asserted
        step(0, 0, 0, 3, 0);
        step(1, 1, 16'h0101, 0, 0);
        chk("redir instr", instr, 16'h0800);
        chk("redir id_en", 16'(id_en), 16'h1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("redir addr", imem_addr, 16'h0100);

        // HALT at 0x0020, then resume at 0x0040
        step(0, 1, 16'h0020, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("halt currPC", currPC, 16'h0020);
        step(0, 0, 0, 0, 0);
        chk("halt flag", 16'(halted), 16'h1);
        step(0, 0, 0, 0, 0);
        chk("halt rd", 16'(imem_rd), 16'h0);
        step(0, 1, 16'h0040, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("resume addr", imem_addr, 16'h0040);

        // wrap at 0xFFFE
        step(0, 1, 16'hFFFC, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("wrap PC_2", PC_2, 16'h0000);
        step(0, 0, 0, 0, 0);
        chk("wrap currPC", currPC, 16'h0000);

        // reset mid-WAIT at 0xFFFE
        step(0, 1, 16'hFFFE, 0, 0);
        step(0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        chk("wait addr", imem_addr, 16'hFFFE);
        #2 rst = 1'b0;
        stall_in = 0; redirect = 0; imem_done = 0;
        #1;
        chk_reset_vals();
        model_reset();
        @(posedge clk); #1 rst = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("post-rst addr", imem_addr, 16'h0000);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 16'($urandom), -1,
                 $urandom_range(0, 29) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
